// File: rtl/axi_ro_pkg.sv
// Shared constants and helpers for the AXI_RO register bank.
// Holds the response code, register indices, reset values and byte-strobe merge.
package axi_ro_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         NUM_REGS      = 4;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_1    = 2'd1;
    localparam logic [1:0] REG_2    = 2'd2;
    localparam logic [1:0] REG_3    = 2'd3;

    localparam logic [31:0] REG_RESET [NUM_REGS] = '{32'h0, 32'h0, 32'h0, 32'h0};

    // Bytes whose strobe is low keep their old contents.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = data[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_ro_lite_regs.sv
// AXI4-Lite slave with four 32-bit byte-strobed registers for the ring-oscillator core.
// One outstanding write and one outstanding read; every response is OKAY.
module axi_ro_lite_regs
    import axi_ro_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

    logic                            aw_held;
    logic [1:0]                      aw_idx_q;
    logic                            w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;
    logic                            bvalid;
    logic                            rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic                            aw_hs;
    logic                            w_hs;
    logic                            ar_hs;
    logic                            commit;
    logic [1:0]                      wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic                            unused_bits;

    assign S_AXI_AWREADY = !aw_held && !bvalid;
    assign S_AXI_WREADY  = !w_held && !bvalid;
    assign S_AXI_ARREADY = !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A write commits as soon as address and data are both available, held or arriving now.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;

    assign reg_q = {regs[REG_3], regs[REG_2], regs[REG_1], regs[REG_CTRL]};

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_RESET[i];
            end
            reg_wr_pulse <= '0;
            bvalid       <= 1'b0;
        end else begin
            reg_wr_pulse <= '0;
            if (commit) begin
                regs[wr_idx]         <= apply_wstrb(regs[wr_idx], wr_data, wr_strb);
                reg_wr_pulse[wr_idx] <= 1'b1;
                bvalid               <= 1'b1;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured before any same-edge write lands, so it sees the old value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= regs[S_AXI_ARADDR[3:2]];
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_ro_lite_regs.sv
// Self-checking bench for axi_ro_lite_regs: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the register bank.
module tb_axi_ro_lite_regs;

    logic         S_AXI_ACLK = 1'b0;
    logic         S_AXI_ARESET;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] exp_regs [4];
    logic [3:0]  exp_pulse;
    logic        exp_bvalid;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [1:0]  aw_q [$];
    logic [31:0] wd_q [$];
    logic [3:0]  ws_q [$];

    axi_ro_lite_regs dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: queue accepted addresses/data, pair them in order, apply the bytes on the pairing edge.
    initial begin
        forever begin
            @(posedge S_AXI_ACLK or posedge S_AXI_ARESET);
            if (S_AXI_ARESET) begin
                for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
                exp_pulse  = 4'h0;
                exp_bvalid = 1'b0;
                exp_rvalid = 1'b0;
                exp_rdata  = 32'h0;
                aw_q.delete();
                wd_q.delete();
                ws_q.delete();
            end else begin
                exp_pulse = 4'h0;
                if (S_AXI_AWVALID && aw_q.size() == 0 && !exp_bvalid) aw_q.push_back(S_AXI_AWADDR[3:2]);
                if (S_AXI_WVALID && wd_q.size() == 0 && !exp_bvalid) begin
                    wd_q.push_back(S_AXI_WDATA);
                    ws_q.push_back(S_AXI_WSTRB);
                end
                if (S_AXI_ARVALID && !exp_rvalid) begin
                    exp_rdata  = exp_regs[S_AXI_ARADDR[3:2]];
                    exp_rvalid = 1'b1;
                end else if (exp_rvalid && S_AXI_RREADY) begin
                    exp_rvalid = 1'b0;
                end
                if (exp_bvalid && S_AXI_BREADY) exp_bvalid = 1'b0;
                if (aw_q.size() > 0 && wd_q.size() > 0) begin
                    logic [1:0]  idx;
                    logic [31:0] d;
                    logic [3:0]  s;
                    idx = aw_q.pop_front();
                    d   = wd_q.pop_front();
                    s   = ws_q.pop_front();
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) exp_regs[idx][8*b +: 8] = d[8*b +: 8];
                    end
                    exp_pulse[idx] = 1'b1;
                    exp_bvalid     = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge S_AXI_ACLK);
            check_output("reg_q", reg_q, {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]});
            check_output("bvalid", S_AXI_BVALID, exp_bvalid);
            check_output("wr_pulse", reg_wr_pulse, exp_pulse);
            check_output("awready", S_AXI_AWREADY, aw_q.size() == 0 && !exp_bvalid);
            check_output("wready", S_AXI_WREADY, wd_q.size() == 0 && !exp_bvalid);
            check_output("arready", S_AXI_ARREADY, !exp_rvalid);
            check_output("rvalid", S_AXI_RVALID, exp_rvalid);
            check_output("bresp", S_AXI_BRESP, 2'b00);
            check_output("rresp", S_AXI_RRESP, 2'b00);
            if (exp_rvalid) check_output("rdata", S_AXI_RDATA, exp_rdata);
        end
    end

    task automatic apply_stimulus();
        S_AXI_AWADDR  = 4'h0;
        S_AXI_AWPROT  = 3'h0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = 32'h0;
        S_AXI_WSTRB   = 4'h0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = 4'h0;
        S_AXI_ARPROT  = 3'h0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
    endtask

    // Entered and left just after a rising edge; returns the loop cycle of each handshake.
    task automatic write_txn(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output int aw_cyc, output int w_cyc);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int c = 0;
        logic [3:0] onehot;
        aw_cyc = -1;
        w_cyc  = -1;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && c < 200) begin
            S_AXI_AWVALID = !aw_done && (c >= aw_dly);
            S_AXI_WVALID  = !w_done && (c >= w_dly);
            @(posedge S_AXI_ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_done = 1'b1; aw_cyc = c; end
            if (S_AXI_WVALID && S_AXI_WREADY) begin w_done = 1'b1; w_cyc = c; end
            c++;
            #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        onehot = 4'b0001 << addr[3:2];
        check_output("write_timeout", aw_done && w_done, 1'b1);
        check_output("b_latency", S_AXI_BVALID, 1'b1);
        check_output("pulse_onehot", reg_wr_pulse, onehot);
    endtask

    task automatic b_phase(input int dly);
        repeat (dly) begin
            @(posedge S_AXI_ACLK);
            #1;
            check_output("b_hold", S_AXI_BVALID, 1'b1);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
        check_output("b_done", S_AXI_BVALID, 1'b0);
    endtask

    task automatic read_txn(input logic [3:0] addr, input int ar_dly, input int r_dly, output logic [31:0] data);
        bit done = 1'b0;
        int c = 0;
        logic [31:0] first;
        S_AXI_ARADDR = addr;
        while (!done && c < 200) begin
            S_AXI_ARVALID = (c >= ar_dly);
            @(posedge S_AXI_ACLK);
            if (S_AXI_ARVALID && S_AXI_ARREADY) done = 1'b1;
            c++;
            #1;
        end
        S_AXI_ARVALID = 1'b0;
        check_output("read_timeout", done, 1'b1);
        check_output("r_latency", S_AXI_RVALID, 1'b1);
        first = S_AXI_RDATA;
        repeat (r_dly) begin
            @(posedge S_AXI_ACLK);
            #1;
            check_output("r_hold_valid", S_AXI_RVALID, 1'b1);
            check_output("r_hold_data", S_AXI_RDATA, first);
            check_output("ar_blocked", S_AXI_ARREADY, 1'b0);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_RREADY = 1'b0;
        check_output("r_done", S_AXI_RVALID, 1'b0);
        data = first;
    endtask

    initial begin
        int awc;
        int wc;
        logic [31:0] rd;
        logic [31:0] ref_vals [4];
        ref_vals[0] = 32'd1; ref_vals[1] = 32'd2; ref_vals[2] = 32'd3; ref_vals[3] = 32'd4;

        apply_stimulus();
        S_AXI_ARESET = 1'b1;
        #1;
        check_output("rst_reg_q", reg_q, 128'h0);
        check_output("rst_bvalid", S_AXI_BVALID, 1'b0);
        check_output("rst_rvalid", S_AXI_RVALID, 1'b0);
        check_output("rst_rdata", S_AXI_RDATA, 32'h0);
        check_output("rst_pulse", reg_wr_pulse, 4'h0);
        check_output("rst_awready", S_AXI_AWREADY, 1'b1);
        repeat (3) @(posedge S_AXI_ACLK);
        #3 S_AXI_ARESET = 1'b0;
        @(posedge S_AXI_ACLK);
        #1;

        $display("[TB] sequential writes and reads");
        for (int i = 0; i < 4; i++) begin
            write_txn(4'(i * 4), ref_vals[i], 4'hF, 0, 0, awc, wc);
            b_phase(0);
        end
        for (int i = 0; i < 4; i++) begin
            read_txn(4'(i * 4), 0, 0, rd);
            check_output("seq_read", rd, ref_vals[i]);
        end

        $display("[TB] partial strobe");
        write_txn(4'h4, 32'hAABBCCDD, 4'b0010, 0, 0, awc, wc);
        b_phase(0);
        check_output("strobe_reg1", reg_q[63:32], 32'h0000CC02);

        $display("[TB] data before address");
        write_txn(4'h4, 32'h12345678, 4'hF, 3, 0, awc, wc);
        check_output("w_before_aw", awc - wc, 3);
        @(posedge S_AXI_ACLK);
        #1;
        check_output("pulse_one_cycle", reg_wr_pulse, 4'h0);
        b_phase(0);
        check_output("reg1_full", reg_q[63:32], 32'h12345678);

        $display("[TB] zero strobe");
        write_txn(4'h8, 32'hFFFFFFFF, 4'h0, 1, 2, awc, wc);
        b_phase(1);
        check_output("zero_strobe_reg2", reg_q[95:64], 32'd3);

        $display("[TB] BREADY held low");
        write_txn(4'hC, 32'hA5A5A5A5, 4'hF, 0, 0, awc, wc);
        S_AXI_AWADDR  = 4'h0;
        S_AXI_WDATA   = 32'h00000055;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        repeat (5) begin
            @(posedge S_AXI_ACLK);
            #1;
            check_output("bp_bvalid", S_AXI_BVALID, 1'b1);
            check_output("bp_awready", S_AXI_AWREADY, 1'b0);
            check_output("bp_wready", S_AXI_WREADY, 1'b0);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
        check_output("bp_awready_after", S_AXI_AWREADY, 1'b1);
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check_output("bp_second_commit", S_AXI_BVALID, 1'b1);
        b_phase(0);
        check_output("bp_reg0", reg_q[31:0], 32'h00000055);
        check_output("bp_reg3", reg_q[127:96], 32'hA5A5A5A5);

        $display("[TB] RREADY held low");
        read_txn(4'h8, 0, 4, rd);
        check_output("rhold_value", rd, 32'd3);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++) begin
            int kind;
            logic [3:0]  wa;
            logic [3:0]  ra;
            logic [31:0] wd;
            logic [3:0]  ws;
            int d0, d1, d2, d3, d4;
            kind = $urandom_range(0, 2);
            wa = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            d0 = $urandom_range(0, 3);
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            d3 = $urandom_range(0, 3);
            d4 = $urandom_range(0, 3);
            if (kind == 0) begin
                write_txn(wa, wd, ws, d0, d1, awc, wc);
                b_phase(d2);
            end else if (kind == 1) begin
                read_txn(ra, d3, d4, rd);
            end else begin
                fork
                    begin
                        int a1, w1;
                        write_txn(wa, wd, ws, d0, d1, a1, w1);
                        b_phase(d2);
                    end
                    begin
                        logic [31:0] r1;
                        read_txn(ra, d3, d4, r1);
                    end
                join
            end
        end

        $display("[TB] reset during pending response");
        write_txn(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, awc, wc);
        #2 S_AXI_ARESET = 1'b1;
        #1;
        check_output("arst_bvalid", S_AXI_BVALID, 1'b0);
        check_output("arst_reg_q", reg_q, 128'h0);
        check_output("arst_pulse", reg_wr_pulse, 4'h0);
        @(posedge S_AXI_ACLK);
        @(posedge S_AXI_ACLK);
        #3 S_AXI_ARESET = 1'b0;
        @(posedge S_AXI_ACLK);
        #1;
        read_txn(4'h0, 0, 0, rd);
        check_output("post_reset_read", rd, 32'h0);

        $display("[TB] reset drops held write data");
        S_AXI_WDATA  = 32'hFFFFFFFF;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_WVALID = 1'b0;
        check_output("w_held_blocks", S_AXI_WREADY, 1'b0);
        #2 S_AXI_ARESET = 1'b1;
        #1;
        check_output("w_held_dropped", S_AXI_WREADY, 1'b1);
        @(posedge S_AXI_ACLK);
        #3 S_AXI_ARESET = 1'b0;
        @(posedge S_AXI_ACLK);
        #1;
        write_txn(4'h8, 32'h00000077, 4'hF, 0, 0, awc, wc);
        b_phase(0);
        check_output("fresh_write", reg_q[95:64], 32'h00000077);

        @(posedge S_AXI_ACLK);
        #1;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
